dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single byte-addressed data memory port (32 x 8-bit, little-endian, combinational read, posedge write).
- Requester 0 is the core load/store unit; requester 1 is the debug/loader port.
- Registers the winning command and drives the memory's rEN/wEN/addr/data lines for exactly one cycle.
- Returns registered read data and an error flag to the requester that issued the access.

Parameters:
- MEM_BYTES, 32: memory size in bytes; sets the legal address range 0..MEM_BYTES-1.
- PRIO_RR, 1: 1 = round-robin arbitration; 0 = fixed priority, requester 0 wins.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- m0_req  in  1  requester 0 command valid; held high until m0_gnt
- m0_rEN  in  4  load code: 1000 LW, 0010 LH, 1010 LHU, 0001 LB, 1001 LBU, 0000 none
- m0_wEN  in  4  store code: 1000 SW, 0010 SH, 0001 SB, 0000 none
- m0_addr  in  32  byte address
- m0_wdata  in  32  store data, right-aligned
- m0_gnt  out  1  one-cycle pulse: command accepted this cycle
- m0_rvalid  out  1  one-cycle pulse: response for requester 0
- m0_rdata  out  32  load result, valid with m0_rvalid
- m0_err  out  1  error flag, valid with m0_rvalid
- m1_*  same set for requester 1
- mem_rEN  out  4  to memory rEN
- mem_wEN  out  4  to memory wEN
- mem_addr  out  32  to memory addr_i
- mem_wdata  out  32  to memory data_i
- mem_rdata  in  32  from memory data_o

Behaviour:
- Clock and reset: one clock CLK. RST is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, last-winner register = 1 (so requester 0 wins first).
- Mid-operation reset: an access in flight is dropped. mem_wEN goes 0 immediately, so no write commits and no rvalid is issued.
- States: IDLE (memory not driven) and ACCESS (memory driven from the command register). Arbitration runs in both states.
- Cycle N, arbitration: any req high -> pick the winner, pulse its gnt, latch {id, rEN, wEN, addr, wdata, err} into the command register. Next state is ACCESS, otherwise IDLE.
- Tie rule: both requesters high -> the requester that did not win last; with PRIO_RR=0, requester 0 always wins. A lone requester always wins.
- Cycle N+1, ACCESS: mem_* lines driven from the command register.
  - A store commits at the end of N+1.
  - A load's mem_rdata is captured at the end of N+1.
- Cycle N+2, response: the issuing requester sees rvalid=1, with rdata (0 for stores) and err. This applies to both loads and stores.
- Throughput: a new grant may occur in the same cycle as an ACCESS, giving 1 access/cycle back-to-back. Latency is 2 cycles from gnt to rvalid.
- IDLE memory lines: mem_rEN=0000, mem_wEN=0000, mem_addr=0, mem_wdata=0. An errored command is also issued with both enables 0000.
- Access size: 4 for LW/SW, 2 for LH/LHU/SH, 1 for LB/LBU/SB.
- Error detection, at latch time; err=1 when any of:
  - rEN and wEN both nonzero
  - both zero
  - either code outside the listed set
  - addr + size - 1 > MEM_BYTES-1, computed at 33-bit width so addr near 2^32 cannot wrap
- Errored command: no write, rdata=0, err=1. It still consumes the slot and produces an rvalid.
- Misaligned but in-range accesses are legal; the memory handles byte composition.
- A requester must not drop req before gnt; once dropped, its command is not served.
- After gnt, a requester may present a new req in the next cycle.

Decomposition:
- Package dmem_pkg holds:
  - localparams for all rEN/wEN codes (LW, LH, LHU, LB, LBU, SW, SH, SB, NONE)
  - state encoding IDLE=0, ACCESS=1
  - a function returning access size from the codes
- One sub-module: dmem_cmd_check (combinational legality and range check, outputs err and size), instantiated once on the arbitrated command before the latch.

Test Plan:
- Reset, then m0 SW addr=4 wdata=0xDEADBEEF -> m0_gnt at N; mem_wEN=1000 and mem_addr=4 at N+1; m0_rvalid at N+2 with err=0. A following LW addr=4 returns 0xDEADBEEF.
- m0 SB addr=8 0x80, then LB addr=8 -> rdata 0xFFFFFF80; LBU addr=8 -> 0x00000080. Same pattern for SH/LH/LHU 0x8001 at addr=10: LH -> 0xFFFF8001, LHU -> 0x00008001.
- m0 and m1 both hold LW requests for 4 cycles -> grants alternate 0,1,0,1 with one grant per cycle; each rvalid arrives 2 cycles after its own gnt.
- Errors, each giving err=1, rdata=0 and the memory byte unchanged:
  - m1 SW addr=30
  - LW addr=0xFFFFFFFE
  - rEN=0011
  - rEN=1000 together with wEN=1000
- RST asserted during the ACCESS cycle of SW addr=0 0x11223344 -> byte 0 is unchanged, no rvalid; outputs are 0 while RST is high.
- PRIO_RR=0, both requesters continuously requesting -> m0 granted every cycle and m1 never.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared codes, state encoding and command record for the data-memory arbiter.
// The load and store codes use separate names even where their bit patterns match.
package dmem_pkg;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] LW   = 4'b1000;
    localparam logic [3:0] LH   = 4'b0010;
    localparam logic [3:0] LHU  = 4'b1010;
    localparam logic [3:0] LB   = 4'b0001;
    localparam logic [3:0] LBU  = 4'b1001;
    localparam logic [3:0] SW   = 4'b1000;
    localparam logic [3:0] SH   = 4'b0010;
    localparam logic [3:0] SB   = 4'b0001;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef struct packed {
        logic        id;
        logic [3:0]  ren;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
    } cmd_t;

    // Returns 0 for an unrecognised code pair; callers treat that case as an error.
    function automatic logic [2:0] access_size(input logic [3:0] ren, input logic [3:0] wen);
        logic [2:0] sz;
        sz = 3'd0;
        case (ren)
            LW:       sz = 3'd4;
            LH, LHU:  sz = 3'd2;
            LB, LBU:  sz = 3'd1;
            default: begin
                case (wen)
                    SW:      sz = 3'd4;
                    SH:      sz = 3'd2;
                    SB:      sz = 3'd1;
                    default: sz = 3'd0;
                endcase
            end
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/dmem_cmd_check.sv
// Combinational legality and range check applied to the arbitrated command.
// The range check uses 33-bit arithmetic so that addresses near 2^32 cannot wrap.
module dmem_cmd_check
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = 32
) (
    input  logic [3:0]  ren,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    output logic        err,
    output logic [2:0]  size
);

    logic        rd_legal;
    logic        wr_legal;
    logic [32:0] end_addr;

    always_comb begin
        size     = access_size(ren, wen);
        rd_legal = (ren == LW) || (ren == LH) || (ren == LHU) || (ren == LB) || (ren == LBU);
        wr_legal = (wen == SW) || (wen == SH) || (wen == SB);
        // end_addr is one past the last byte touched.
        end_addr = {1'b0, addr} + {30'd0, size};
        err = ((ren != NONE) && (wen != NONE))
           || ((ren == NONE) && (wen == NONE))
           || ((ren != NONE) && !rd_legal)
           || ((wen != NONE) && !wr_legal)
           || (end_addr > 33'(MEM_BYTES));
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single data-memory port: grant, latch,
// issue to memory for one cycle, and return the registered response.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = 32,
    parameter int PRIO_RR   = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        m0_req,
    input  logic [3:0]  m0_rEN,
    input  logic [3:0]  m0_wEN,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [3:0]  m1_rEN,
    input  logic [3:0]  m1_wEN,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [3:0]  mem_rEN,
    output logic [3:0]  mem_wEN,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    cmd_t        cmd_q, cmd_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    logic        grant;
    logic        win_id;
    logic [3:0]  sel_ren, sel_wen;
    logic [31:0] sel_addr, sel_wdata;
    logic        chk_err;
    logic [2:0]  chk_size;
    logic        issue;

    always_comb begin
        grant  = m0_req | m1_req;
        win_id = 1'b0;
        if (m0_req && m1_req) begin
            win_id = (PRIO_RR != 0) ? ~last_q : 1'b0;
        end else begin
            win_id = m1_req;
        end
    end

    assign sel_ren   = win_id ? m1_rEN   : m0_rEN;
    assign sel_wen   = win_id ? m1_wEN   : m0_wEN;
    assign sel_addr  = win_id ? m1_addr  : m0_addr;
    assign sel_wdata = win_id ? m1_wdata : m0_wdata;

    dmem_cmd_check #(.MEM_BYTES(MEM_BYTES)) u_check (
        .ren  (sel_ren),
        .wen  (sel_wen),
        .addr (sel_addr),
        .err  (chk_err),
        .size (chk_size)
    );

    always_comb begin
        state_d     = IDLE;
        last_d      = last_q;
        cmd_d       = cmd_q;
        rsp_valid_d = (state_q == ACCESS);
        rsp_id_d    = cmd_q.id;
        rsp_err_d   = (state_q == ACCESS) && cmd_q.err;
        rsp_data_d  = 32'd0;
        if (grant) begin
            state_d = ACCESS;
            last_d  = win_id;
            cmd_d   = '{id: win_id, ren: sel_ren, wen: sel_wen, addr: sel_addr,
                        wdata: sel_wdata, err: chk_err};
        end
        if (issue && (cmd_q.ren != NONE)) begin
            rsp_data_d = mem_rdata;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            cmd_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cmd_q       <= cmd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Errored commands still occupy the ACCESS slot but never enable the memory.
    assign issue     = (state_q == ACCESS) && !cmd_q.err;
    assign mem_rEN   = issue ? cmd_q.ren : NONE;
    assign mem_wEN   = issue ? cmd_q.wen : NONE;
    assign mem_addr  = (state_q == ACCESS) ? cmd_q.addr  : 32'd0;
    assign mem_wdata = (state_q == ACCESS) ? cmd_q.wdata : 32'd0;

    assign m0_gnt    = grant & ~win_id & ~RST;
    assign m1_gnt    = grant &  win_id & ~RST;
    assign m0_rvalid = rsp_valid_q & ~rsp_id_q;
    assign m1_rvalid = rsp_valid_q &  rsp_id_q;
    assign m0_rdata  = m0_rvalid ? rsp_data_q : 32'd0;
    assign m1_rdata  = m1_rvalid ? rsp_data_q : 32'd0;
    assign m0_err    = m0_rvalid & rsp_err_q;
    assign m1_err    = m1_rvalid & rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 32-byte memory
// and a reference byte array used to predict every response.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic        req_r[2];
    logic [3:0]  ren_r[2];
    logic [3:0]  wen_r[2];
    logic [31:0] addr_r[2];
    logic [31:0] wdata_r[2];

    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [3:0]  mem_rEN, mem_wEN;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        gnt_w[2];
    assign gnt_w[0] = m0_gnt;
    assign gnt_w[1] = m1_gnt;

    dmem_arbiter #(.MEM_BYTES(32), .PRIO_RR(1)) dut (
        .CLK(CLK), .RST(RST),
        .m0_req(req_r[0]), .m0_rEN(ren_r[0]), .m0_wEN(wen_r[0]), .m0_addr(addr_r[0]),
        .m0_wdata(wdata_r[0]), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m0_err(m0_err),
        .m1_req(req_r[1]), .m1_rEN(ren_r[1]), .m1_wEN(wen_r[1]), .m1_addr(addr_r[1]),
        .m1_wdata(wdata_r[1]), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .m1_err(m1_err),
        .mem_rEN(mem_rEN), .mem_wEN(mem_wEN), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Fixed-priority instance; only its grants are examined.
    logic        pr_req;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata, p_addr, p_wdata;
    logic [3:0]  p_rEN, p_wEN;

    dmem_arbiter #(.MEM_BYTES(32), .PRIO_RR(0)) dut_fp (
        .CLK(CLK), .RST(RST),
        .m0_req(pr_req), .m0_rEN(LW), .m0_wEN(NONE), .m0_addr(32'd0), .m0_wdata(32'd0),
        .m0_gnt(p0_gnt), .m0_rvalid(p0_rvalid), .m0_rdata(p0_rdata), .m0_err(p0_err),
        .m1_req(pr_req), .m1_rEN(LW), .m1_wEN(NONE), .m1_addr(32'd4), .m1_wdata(32'd0),
        .m1_gnt(p1_gnt), .m1_rvalid(p1_rvalid), .m1_rdata(p1_rdata), .m1_err(p1_err),
        .mem_rEN(p_rEN), .mem_wEN(p_wEN), .mem_addr(p_addr), .mem_wdata(p_wdata),
        .mem_rdata(32'd0)
    );

    function automatic logic [31:0] load_fmt(input logic [3:0] ren, input logic [31:0] w);
        case (ren)
            LW:      return w;
            LH:      return {{16{w[15]}}, w[15:0]};
            LHU:     return {16'd0, w[15:0]};
            LB:      return {{24{w[7]}}, w[7:0]};
            LBU:     return {24'd0, w[7:0]};
            default: return 32'd0;
        endcase
    endfunction

    function automatic int store_bytes(input logic [3:0] wen);
        case (wen)
            SW:      return 4;
            SH:      return 2;
            SB:      return 1;
            default: return 0;
        endcase
    endfunction

    logic [7:0] mem[32];
    bit         mem_inited = 1'b0;
    logic [31:0] raw_word;

    always_comb begin
        raw_word = 32'd0;
        for (int i = 0; i < 4; i++) raw_word[8*i +: 8] = mem[5'(mem_addr + 32'(i))];
        mem_rdata = load_fmt(mem_rEN, raw_word);
    end

    always @(posedge CLK) begin
        if (!mem_inited) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'(i * 7 + 3);
            mem_inited <= 1'b1;
        end else begin
            for (int i = 0; i < 4; i++)
                if (i < store_bytes(mem_wEN)) mem[5'(mem_addr + 32'(i))] <= mem_wdata[8*i +: 8];
        end
    end

    logic [7:0] ref_mem[32];

    function automatic bit exp_err(input logic [3:0] ren, input logic [3:0] wen, input logic [31:0] addr);
        int sz;
        if (ren != 4'd0 && wen != 4'd0) return 1'b1;
        if (ren == 4'd0 && wen == 4'd0) return 1'b1;
        if (ren != 4'd0) begin
            case (ren)
                4'b1000:          sz = 4;
                4'b0010, 4'b1010: sz = 2;
                4'b0001, 4'b1001: sz = 1;
                default:          return 1'b1;
            endcase
        end else begin
            case (wen)
                4'b1000: sz = 4;
                4'b0010: sz = 2;
                4'b0001: sz = 1;
                default: return 1'b1;
            endcase
        end
        return (longint'(addr) + longint'(sz) - 1) > 31;
    endfunction

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic predict(input int p, input logic [3:0] ren, input logic [3:0] wen,
                           input logic [31:0] addr, input logic [31:0] wdata, input int gcyc);
        exp_t e;
        logic [31:0] raw;
        e.err  = exp_err(ren, wen, addr);
        e.cyc  = gcyc + 2;
        e.data = 32'd0;
        raw    = 32'd0;
        for (int i = 0; i < 4; i++) raw[8*i +: 8] = ref_mem[5'(addr + 32'(i))];
        if (!e.err) begin
            if (ren != NONE) e.data = load_fmt(ren, raw);
            else for (int i = 0; i < store_bytes(wen); i++) ref_mem[5'(addr + 32'(i))] = wdata[8*i +: 8];
        end
        if (p == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Presents a command from requester p and holds it until granted; returns the grant cycle.
    task automatic issue(input int p, input logic [3:0] ren, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit track,
                         output int gcyc);
        @(negedge CLK);
        req_r[p] = 1'b1; ren_r[p] = ren; wen_r[p] = wen; addr_r[p] = addr; wdata_r[p] = wdata;
        gcyc = -1;
        for (int i = 0; i < 40; i++) begin
            #4;
            if (gnt_w[p]) begin
                gcyc = cyc;
                break;
            end
            @(negedge CLK);
        end
        if (gcyc < 0) begin
            chk($sformatf("gnt_timeout_m%0d", p), 32'd0, 32'd1);
            req_r[p] = 1'b0;
        end else begin
            if (track) predict(p, ren, wen, addr, wdata, gcyc);
            @(posedge CLK);
            #1;
            req_r[p] = 1'b0;
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (m0_rvalid) begin
                if (q0.size() == 0) chk("m0_unexpected_rvalid", 32'd1, 32'd0);
                else begin
                    e = q0.pop_front();
                    chk("m0_rdata", m0_rdata, e.data);
                    chk("m0_err", 32'(m0_err), 32'(e.err));
                    chk("m0_latency_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (m1_rvalid) begin
                if (q1.size() == 0) chk("m1_unexpected_rvalid", 32'd1, 32'd0);
                else begin
                    e = q1.pop_front();
                    chk("m1_rdata", m1_rdata, e.data);
                    chk("m1_err", 32'(m1_err), 32'(e.err));
                    chk("m1_latency_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g, g0a, g0b, g1a, g1b;
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i * 7 + 3);
        for (int p = 0; p < 2; p++) begin
            req_r[p] = 1'b0; ren_r[p] = NONE; wen_r[p] = NONE; addr_r[p] = '0; wdata_r[p] = '0;
        end
        pr_req = 1'b0;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_mem_wEN", 32'(mem_wEN), 32'd0);
        chk("rst_mem_rEN", 32'(mem_rEN), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
        RST = 1'b0;

        issue(0, NONE, SW, 32'd4, 32'hDEADBEEF, 1'b1, g);
        chk("sw_access_wEN", 32'(mem_wEN), 32'(SW));
        chk("sw_access_addr", mem_addr, 32'd4);
        chk("sw_access_wdata", mem_wdata, 32'hDEADBEEF);
        issue(0, LW,   NONE, 32'd4,  32'd0,     1'b1, g);
        issue(0, NONE, SB,   32'd8,  32'h80,    1'b1, g);
        issue(0, LB,   NONE, 32'd8,  32'd0,     1'b1, g);
        issue(0, LBU,  NONE, 32'd8,  32'd0,     1'b1, g);
        issue(0, NONE, SH,   32'd10, 32'h8001,  1'b1, g);
        issue(0, LH,   NONE, 32'd10, 32'd0,     1'b1, g);
        issue(0, LHU,  NONE, 32'd10, 32'd0,     1'b1, g);
        issue(1, LW,   NONE, 32'd28, 32'd0,     1'b1, g);
        issue(1, NONE, SB,   32'd31, 32'h5A,    1'b1, g);
        issue(1, LBU,  NONE, 32'd31, 32'd0,     1'b1, g);

        issue(1, NONE,    SW,   32'd30,        32'hAABBCCDD, 1'b1, g);
        issue(0, LW,      NONE, 32'hFFFFFFFE,  32'd0,        1'b1, g);
        issue(0, 4'b0011, NONE, 32'd12,        32'd0,        1'b1, g);
        issue(0, LW,      SW,   32'd12,        32'h55555555, 1'b1, g);
        issue(1, NONE,    NONE, 32'd12,        32'd0,        1'b1, g);
        repeat (4) @(negedge CLK);
        chk("err_byte30", 32'(mem[30]), 32'(ref_mem[30]));
        chk("err_byte31", 32'(mem[31]), 32'(ref_mem[31]));
        for (int i = 12; i < 16; i++) chk($sformatf("err_byte%0d", i), 32'(mem[i]), 32'(ref_mem[i]));

        issue(0, NONE, SW, 32'd0, 32'h11223344, 1'b0, g);
        chk("rst_pre_wEN", 32'(mem_wEN), 32'(SW));
        RST = 1'b1;
        #1;
        chk("rst_mid_wEN", 32'(mem_wEN), 32'd0);
        chk("rst_mid_addr", mem_addr, 32'd0);
        chk("rst_mid_outputs", 32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err}), 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_byte0", 32'(mem[0]), 32'(ref_mem[0]));

        fork
            begin
                issue(0, LW, NONE, 32'd0, 32'd0, 1'b1, g0a);
                issue(0, LW, NONE, 32'd4, 32'd0, 1'b1, g0b);
            end
            begin
                issue(1, LW, NONE, 32'd8,  32'd0, 1'b1, g1a);
                issue(1, LW, NONE, 32'd12, 32'd0, 1'b1, g1b);
            end
        join
        chk("rr_m1_first", 32'(g1a - g0a), 32'd1);
        chk("rr_m0_second", 32'(g0b - g0a), 32'd2);
        chk("rr_m1_second", 32'(g1b - g0a), 32'd3);

        @(negedge CLK);
        pr_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #4;
            chk("fp_m0_gnt", 32'(p0_gnt), 32'd1);
            chk("fp_m1_gnt", 32'(p1_gnt), 32'd0);
            @(negedge CLK);
        end
        pr_req = 1'b0;

        repeat (4) @(negedge CLK);
        chk("drain_q0", 32'(q0.size()), 32'd0);
        chk("drain_q1", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
